seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 131 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: cycles an active-low anode across NUM_DIGITS
// digits, with tear-free frame updates, leading-zero suppression and PWM brightness.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int SLOT = REFRESH_DIV / 8;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp_val, pend_val;
  logic [NUM_DIGITS-1:0]   disp_dp, disp_blank, pend_dp, pend_blank;
  logic                    pend_valid;
  logic                    slot_end, frame_end;

  logic [3:0]              nib;
  logic                    lead_zero, on_phase, hide;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [6:0]              segs_nxt;
  logic                    dp_nxt;

  // Active-low GFEDCBA hex glyphs
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  assign slot_end  = (presc == PRESC_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Scan counters plus double-buffered display contents; display only swaps at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end)
        idx <= frame_end ? '0 : idx + 1'b1;
      if (frame_end && load) begin
        disp_val   <= value_in;
        disp_dp    <= dp_in;
        disp_blank <= blank_in;
        pend_valid <= 1'b0;
      end else if (frame_end && pend_valid) begin
        disp_val   <= pend_val;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
        pend_valid <= 1'b0;
      end
      if (load && !frame_end) begin
        pend_val   <= value_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    nib       = disp_val[int'(idx)*4 +: 4];
    lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && disp_val[4*i +: 4] != 4'h0)
        lead_zero = 1'b0;
    end
    on_phase  = int'(presc) < (int'(brightness) + 1) * SLOT;
    hide      = disp_blank[idx] | (lz_suppress & (idx != '0) & lead_zero) | ~on_phase;
    anode_nxt = hide ? '1 : ~(NUM_DIGITS'(1) << idx);
    segs_nxt  = hide ? 7'b1111111 : hex_glyph(nib);
    dp_nxt    = hide | ~disp_dp[idx];
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode      <= '1;
      segs       <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_nxt;
      segs       <= segs_nxt;
      dp         <= dp_nxt;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=8.
module tb_seven_seg_scanner;
  localparam int ND = 4;
  localparam int RD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        lz_suppress = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic [3:0]  anode;
  logic [6:0]  segs;
  logic        dp;
  logic        frame_done;

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .lz_suppress(lz_suppress),
    .brightness(brightness), .anode(anode), .segs(segs), .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] segs;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] scan_segs [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

  int          m_presc, m_idx;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_bl, p_dp, p_bl;
  bit          p_vld;

  logic [3:0]  last_anode;
  logic [6:0]  last_segs;
  logic        last_fd;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_idx = 0;
    m_val = '0; m_dp = '0; m_bl = '0;
    p_val = '0; p_dp = '0; p_bl = '0; p_vld = 0;
    sb_q.delete();
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit   hide, lz_hit;
    int   nib;
    nib    = int'((m_val >> (4*m_idx)) & 16'hF);
    lz_hit = (m_idx > 0) && lz_suppress && ((m_val >> (4*m_idx)) == 16'h0);
    hide   = m_bl[m_idx] || lz_hit || (m_presc >= int'(brightness) + 1);
    e.fd   = (m_presc == RD-1) && (m_idx == ND-1);
    e.anode = 4'hF;
    if (hide) begin
      e.segs = 7'h7F;
      e.dp   = 1'b1;
    end else begin
      e.anode[m_idx] = 1'b0;
      e.segs = glyph_tbl[nib];
      e.dp   = ~m_dp[m_idx];
    end
    return e;
  endfunction

  task automatic model_advance();
    bit slot_end, frame_end;
    slot_end  = (m_presc == RD-1);
    frame_end = slot_end && (m_idx == ND-1);
    if (frame_end) begin
      if (load) begin
        m_val = value_in; m_dp = dp_in; m_bl = blank_in; p_vld = 0;
      end else if (p_vld) begin
        m_val = p_val; m_dp = p_dp; m_bl = p_bl; p_vld = 0;
      end
    end else if (load) begin
      p_val = value_in; p_dp = dp_in; p_bl = blank_in; p_vld = 1;
    end
    m_presc = slot_end ? 0 : m_presc + 1;
    if (slot_end) m_idx = (m_idx + 1) % ND;
  endtask

  task automatic step();
    exp_t e;
    sb_q.push_back(model_out());
    model_advance();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("anode", anode, e.anode);
    chk("segs", segs, e.segs);
    chk("dp", dp, e.dp);
    chk("frame_done", frame_done, e.fd);
    chk("one_anode", ($countones(~anode) <= 1), 1);
    last_anode = anode;
    last_segs  = segs;
    last_fd    = frame_done;
    load = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value_in = v; dp_in = d; blank_in = b; load = 1'b1;
    step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model's pre-edge state matches; idx < 0 means any digit.
  task automatic align(input int pr, input int ix);
    int cnt;
    cnt = 0;
    while (!(m_presc == pr && (ix < 0 || m_idx == ix)) && cnt < 64) begin
      step();
      cnt++;
    end
    if (cnt >= 64) chk("align_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_anode"}, anode, 4'hF);
    chk({tag, "_segs"}, segs, 7'h7F);
    chk({tag, "_dp"}, dp, 1'b1);
    chk({tag, "_fd"}, frame_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, gap;
    logic [3:0] ea;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Scan pattern of 12AF at full brightness
    brightness = 3'd7;
    do_load(16'h12AF, 4'h0, 4'h0);
    align(0, 0);
    cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      ea = ~(4'b0001 << (k / 8));
      chk("scan_anode", last_anode, ea);
      chk("scan_segs", last_segs, scan_segs[k / 8]);
      if (last_fd) cnt++;
    end
    chk("fd_per_frame", cnt, 1);
    chk("fd_last_cycle", last_fd, 1);
    gap = 0;
    do begin step(); gap++; end while (!last_fd && gap < 100);
    chk("fd_period", gap, 32);

    // Tear-free update mid-frame
    align(4, 1);
    do_load(16'h0003, 4'h0, 4'h0);
    step();
    chk("old_kept", last_segs, 7'h08);
    align(0, 0);
    step();
    chk("new_digit0", last_segs, 7'h30);
    run(31);

    // Leading-zero suppression on an all-zero value
    lz_suppress = 1'b1;
    do_load(16'h0000, 4'h0, 4'h0);
    align(0, 0);
    cnt = 0; gap = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (!last_anode[0]) cnt++;
      if (last_anode[3:1] != 3'b111) gap++;
    end
    chk("lz_digit0_on", cnt, 8);
    chk("lz_upper_off", gap, 0);
    do_load(16'h0100, 4'b0100, 4'h0);
    run(70);
    lz_suppress = 1'b0;

    // Brightness duty
    brightness = 3'd0;
    align(0, -1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin step(); if (last_anode != 4'hF) cnt++; end
    chk("bright0_on", cnt, 1);
    brightness = 3'd3;
    align(0, -1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin step(); if (last_anode != 4'hF) cnt++; end
    chk("bright3_on", cnt, 4);
    brightness = 3'd7;

    // Load coincident with the frame wrap
    align(7, 3);
    do_load(16'h5A5A, 4'b0001, 4'h0);
    step();
    chk("wrap_load_segs", last_segs, 7'h08);
    run(40);

    // Reset mid-slot discards pending load
    align(3, 2);
    do_load(16'h7777, 4'h0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    model_reset();
    rst_n = 1'b1;
    run(33);
    align(0, 0);
    step();
    chk("pend_lost", last_segs, 7'h40);

    // Random values, decimal points, blanks and suppression
    for (int r = 0; r < 8; r++) begin
      lz_suppress = 1'($urandom_range(0, 1));
      brightness  = 3'($urandom_range(0, 7));
      run($urandom_range(0, 20));
      do_load(16'($urandom & (r[0] ? 32'h00FF : 32'hFFFF)), 4'($urandom), 4'($urandom & 32'h5));
      run(40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
